// File: rtl/spi_cmd_frame_decoder.sv
// spi_cmd_frame_decoder: assembles fixed 9-byte SPI command frames, validates
// byte order, XOR checksum and command fields, and decodes each good frame into
// a camera capture command, a camera I2C byte or a hard-reset pulse.
module spi_cmd_frame_decoder #(
    parameter int NUM_CAMS        = 2,
    parameter int TS_WIDTH        = 28,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int CHECKSUM_EN     = 1,
    parameter int HARD_RST_CYCLES = 4
) (
    input  logic                sysClk,
    input  logic                sysRst_n,
    input  logic [7:0]          spi_byte,
    input  logic                spi_input_valid,
    input  logic [3:0]          spi_byte_num,
    output logic [7:0]          cam_i2c_byte,
    output logic [1:0]          compression,
    output logic                RGB,
    output logic [1:0]          cam_id,
    output logic [TS_WIDTH-1:0] timestamp,
    output logic                trigger,
    output logic [15:0]         trigger_index,
    output logic                cam_interface_output_valid,
    output logic                cam_i2c_output_valid,
    output logic                hard_reset,
    output logic                err_seq,
    output logic                err_timeout,
    output logic                err_cksum,
    output logic                err_cmd,
    output logic [7:0]          good_frame_count
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HR_W = (HARD_RST_CYCLES > 1) ? $clog2(HARD_RST_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HR_W-1:0] HR_LAST     = HR_W'(HARD_RST_CYCLES - 1);
    localparam logic [2:0]      NUM_CAMS_L  = 3'(NUM_CAMS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // XOR of the eight payload bytes (byte i at bits [8*i +: 8])
    function automatic logic [7:0] frame_xor(input logic [63:0] bytes);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ bytes[8*i +: 8];
        end
        return acc;
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        expected_r;
    logic [3:0]        expected_s;
    logic [TO_W-1:0]   timeout_r;
    logic [TO_W-1:0]   timeout_s;
    logic [71:0]       frame_r;
    logic [HR_W-1:0]   hr_cnt_r;

    logic              store_en_s;
    logic              err_seq_s;
    logic              err_to_s;
    logic              err_ck_s;
    logic              err_cmd_s;
    logic              cap_ok_s;
    logic              i2c_ok_s;
    logic              hr_ok_s;

    // frame field views; byte 0 occupies the low bits
    logic [7:0]        hdr_s;
    logic [31:0]       ts32_s;
    logic [15:0]       tidx_s;
    logic [7:0]        b7_s;
    logic [7:0]        b8_s;
    logic              cksum_bad_s;
    logic              cam_bad_s;

    assign hdr_s       = frame_r[7:0];
    assign ts32_s      = {frame_r[15:8], frame_r[23:16], frame_r[31:24], frame_r[39:32]};
    assign tidx_s      = {frame_r[47:40], frame_r[55:48]};
    assign b7_s        = frame_r[63:56];
    assign b8_s        = frame_r[71:64];
    assign cksum_bad_s = (CHECKSUM_EN != 0) && (frame_xor(frame_r[63:0]) != b8_s);
    assign cam_bad_s   = ({1'b0, hdr_s[5:4]} >= NUM_CAMS_L);

    // state, byte-index and timeout registers
    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state_r    <= ST_IDLE;
            expected_r <= 4'd0;
            timeout_r  <= '0;
        end else begin
            state_r    <= state_s;
            expected_r <= expected_s;
            timeout_r  <= timeout_s;
        end
    end

    // next-state logic, byte acceptance, frame validation and error detection
    always_comb begin
        state_s    = state_r;
        expected_s = expected_r;
        timeout_s  = timeout_r;
        store_en_s = 1'b0;
        err_seq_s  = 1'b0;
        err_to_s   = 1'b0;
        err_ck_s   = 1'b0;
        err_cmd_s  = 1'b0;
        cap_ok_s   = 1'b0;
        i2c_ok_s   = 1'b0;
        hr_ok_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timeout_s = '0;
                if (spi_input_valid) begin
                    if (spi_byte_num == 4'd0) begin
                        store_en_s = 1'b1;
                        expected_s = 4'd1;
                        state_s    = ST_RECV;
                    end else begin
                        err_seq_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (spi_input_valid) begin
                    timeout_s = '0;
                    if (spi_byte_num == expected_r) begin
                        store_en_s = 1'b1;
                        if (expected_r == 4'd8) begin
                            expected_s = 4'd0;
                            state_s    = ST_CHECK;
                        end else begin
                            expected_s = expected_r + 4'd1;
                        end
                    end else if (spi_byte_num == 4'd0) begin
                        store_en_s = 1'b1;
                        expected_s = 4'd1;
                    end else begin
                        err_seq_s  = 1'b1;
                        expected_s = 4'd0;
                        state_s    = ST_IDLE;
                    end
                end else if (timeout_r == TO_LAST) begin
                    err_to_s   = 1'b1;
                    timeout_s  = '0;
                    expected_s = 4'd0;
                    state_s    = ST_IDLE;
                end else begin
                    timeout_s  = timeout_r + 1'b1;
                end
            end
            ST_CHECK: begin
                timeout_s = '0;
                state_s   = ST_IDLE;
                // hard reset does not address a camera, so cam_id is only
                // range-checked for capture and i2c commands
                if (cksum_bad_s) begin
                    err_ck_s  = 1'b1;
                end else if (hdr_s[7:6] == 2'b11) begin
                    err_cmd_s = 1'b1;
                end else if (hdr_s[7:6] == 2'b10) begin
                    hr_ok_s   = 1'b1;
                end else if (cam_bad_s) begin
                    err_cmd_s = 1'b1;
                end else if (hdr_s[7:6] == 2'b00) begin
                    cap_ok_s  = 1'b1;
                end else begin
                    i2c_ok_s  = 1'b1;
                end
                // byte 0 of the next frame may arrive while the check runs
                if (spi_input_valid) begin
                    if (spi_byte_num == 4'd0) begin
                        store_en_s = 1'b1;
                        expected_s = 4'd1;
                        state_s    = ST_RECV;
                    end else begin
                        err_seq_s  = 1'b1;
                    end
                end else begin
                    expected_s = 4'd0;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                expected_s = 4'd0;
                timeout_s  = '0;
            end
        endcase
    end

    // frame buffer: write the accepted byte into its slot
    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            frame_r <= 72'h0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (store_en_s && (spi_byte_num == 4'(i))) begin
                    frame_r[8*i +: 8] <= spi_byte;
                end
            end
        end
    end

    // registered decoded fields, strobes, hard-reset pulse and frame counter
    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            cam_i2c_byte               <= 8'h00;
            compression                <= 2'b00;
            RGB                        <= 1'b0;
            cam_id                     <= 2'b00;
            timestamp                  <= '0;
            trigger                    <= 1'b0;
            trigger_index              <= 16'h0000;
            cam_interface_output_valid <= 1'b0;
            cam_i2c_output_valid       <= 1'b0;
            hard_reset                 <= 1'b0;
            hr_cnt_r                   <= '0;
            err_seq                    <= 1'b0;
            err_timeout                <= 1'b0;
            err_cksum                  <= 1'b0;
            err_cmd                    <= 1'b0;
            good_frame_count           <= 8'h00;
        end else begin
            cam_interface_output_valid <= cap_ok_s;
            cam_i2c_output_valid       <= i2c_ok_s;
            err_seq                    <= err_seq_s;
            err_timeout                <= err_to_s;
            err_cksum                  <= err_ck_s;
            err_cmd                    <= err_cmd_s;
            if (cap_ok_s) begin
                cam_id        <= hdr_s[5:4];
                compression   <= hdr_s[3:2];
                RGB           <= hdr_s[1];
                timestamp     <= ts32_s[TS_WIDTH-1:0];
                trigger       <= b7_s[0];
                trigger_index <= tidx_s;
            end else if (i2c_ok_s) begin
                cam_id        <= hdr_s[5:4];
                cam_i2c_byte  <= b7_s;
            end else begin
                cam_id        <= cam_id;
            end
            if (cap_ok_s || i2c_ok_s || hr_ok_s) begin
                good_frame_count <= good_frame_count + 8'd1;
            end else begin
                good_frame_count <= good_frame_count;
            end
            // a new command reloads the width count, extending the pulse
            if (hr_ok_s) begin
                hard_reset <= 1'b1;
                hr_cnt_r   <= HR_LAST;
            end else if (hr_cnt_r != '0) begin
                hr_cnt_r   <= hr_cnt_r - 1'b1;
            end else begin
                hard_reset <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_frame_decoder.sv
// Testbench for spi_cmd_frame_decoder: directed frames, a frame-level outcome
// model with a per-cycle output comparison, and literal spot checks.
module tb_spi_cmd_frame_decoder;

    localparam int TS   = 28;
    localparam int TOUT = 1000;
    localparam int HRC  = 4;

    localparam int K_CAP = 0;
    localparam int K_I2C = 1;
    localparam int K_HR  = 2;
    localparam int K_SEQ = 3;
    localparam int K_TO  = 4;
    localparam int K_CK  = 5;
    localparam int K_CMD = 6;

    logic        sysClk = 1'b0;
    logic        sysRst_n = 1'b0;
    logic [7:0]  spi_byte = 8'h00;
    logic        spi_input_valid = 1'b0;
    logic [3:0]  spi_byte_num = 4'd0;

    logic [7:0]  cam_i2c_byte;
    logic [1:0]  compression;
    logic        RGB;
    logic [1:0]  cam_id;
    logic [TS-1:0] timestamp;
    logic        trigger;
    logic [15:0] trigger_index;
    logic        cam_interface_output_valid;
    logic        cam_i2c_output_valid;
    logic        hard_reset;
    logic        err_seq, err_timeout, err_cksum, err_cmd;
    logic [7:0]  good_frame_count;

    logic [7:0]  d2_i2c;
    logic [1:0]  d2_comp;
    logic        d2_rgb;
    logic [1:0]  d2_cam;
    logic [31:0] d2_ts;
    logic        d2_trig;
    logic [15:0] d2_ti;
    logic        d2_cv, d2_iv, d2_hr, d2_es, d2_et, d2_ec, d2_em;
    logic [7:0]  d2_cnt;

    spi_cmd_frame_decoder #(.NUM_CAMS(2), .TS_WIDTH(TS), .TIMEOUT_CYCLES(TOUT),
                            .CHECKSUM_EN(1), .HARD_RST_CYCLES(HRC)) dut (
        .sysClk(sysClk), .sysRst_n(sysRst_n), .spi_byte(spi_byte),
        .spi_input_valid(spi_input_valid), .spi_byte_num(spi_byte_num),
        .cam_i2c_byte(cam_i2c_byte), .compression(compression), .RGB(RGB),
        .cam_id(cam_id), .timestamp(timestamp), .trigger(trigger),
        .trigger_index(trigger_index),
        .cam_interface_output_valid(cam_interface_output_valid),
        .cam_i2c_output_valid(cam_i2c_output_valid), .hard_reset(hard_reset),
        .err_seq(err_seq), .err_timeout(err_timeout), .err_cksum(err_cksum),
        .err_cmd(err_cmd), .good_frame_count(good_frame_count)
    );

    spi_cmd_frame_decoder #(.NUM_CAMS(4), .TS_WIDTH(32), .TIMEOUT_CYCLES(TOUT),
                            .CHECKSUM_EN(0), .HARD_RST_CYCLES(HRC)) dut2 (
        .sysClk(sysClk), .sysRst_n(sysRst_n), .spi_byte(spi_byte),
        .spi_input_valid(spi_input_valid), .spi_byte_num(spi_byte_num),
        .cam_i2c_byte(d2_i2c), .compression(d2_comp), .RGB(d2_rgb),
        .cam_id(d2_cam), .timestamp(d2_ts), .trigger(d2_trig),
        .trigger_index(d2_ti),
        .cam_interface_output_valid(d2_cv), .cam_i2c_output_valid(d2_iv),
        .hard_reset(d2_hr), .err_seq(d2_es), .err_timeout(d2_et),
        .err_cksum(d2_ec), .err_cmd(d2_em), .good_frame_count(d2_cnt)
    );

    always #5 sysClk = ~sysClk;

    int cyc = 0;
    always @(posedge sysClk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        int          kind;
        logic [71:0] f;
    } ev_t;

    ev_t         sched[$];
    int          checks = 0;
    int          errors = 0;
    int          last_c = 0;
    int          hr_seen = 0;
    int          hr_end = -1;

    logic [7:0]  m_i2c;
    logic [1:0]  m_comp;
    logic        m_rgb;
    logic [1:0]  m_cam;
    logic [TS-1:0] m_ts;
    logic        m_trig;
    logic [15:0] m_ti;
    logic [7:0]  m_cnt;

    function automatic logic [7:0] byte_of(input logic [71:0] f, input int i);
        return f[8*i +: 8];
    endfunction

    // Build a frame with a correct checksum; byte 0 in the low bits
    function automatic logic [71:0] mk(input logic [7:0] h, input logic [31:0] ts,
                                       input logic [15:0] ti, input logic [7:0] b7);
        logic [71:0] f;
        f = {h ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0] ^ ti[15:8] ^ ti[7:0] ^ b7,
             b7, ti[7:0], ti[15:8], ts[7:0], ts[15:8], ts[23:16], ts[31:24], h};
        return f;
    endfunction

    // Outcome of a complete frame for NUM_CAMS=2 with checksum checking
    function automatic int judge(input logic [71:0] f);
        logic [7:0] x;
        logic [1:0] op;
        x = 8'h00;
        for (int i = 0; i < 8; i++) x = x ^ f[8*i +: 8];
        op = f[7:6];
        if (x != f[71:64])                 return K_CK;
        if (op == 2'b11)                   return K_CMD;
        if (op == 2'b10)                   return K_HR;
        if (int'(f[5:4]) >= 2)             return K_CMD;
        return int'(op);
    endfunction

    task automatic model_clear();
        sched.delete();
        m_i2c = 8'h00; m_comp = 2'b00; m_rgb = 1'b0; m_cam = 2'b00;
        m_ts = '0; m_trig = 1'b0; m_ti = 16'h0000; m_cnt = 8'h00;
        hr_end = -1;
    endtask

    task automatic apply(input int kind, input logic [71:0] f);
        logic [31:0] ts32;
        ts32 = {f[15:8], f[23:16], f[31:24], f[39:32]};
        if (kind == K_CAP) begin
            m_cam = f[5:4]; m_comp = f[3:2]; m_rgb = f[1];
            m_ts = ts32[TS-1:0]; m_trig = f[56]; m_ti = {f[47:40], f[55:48]};
            m_cnt = m_cnt + 8'd1;
        end else if (kind == K_I2C) begin
            m_cam = f[5:4]; m_i2c = f[63:56];
            m_cnt = m_cnt + 8'd1;
        end else if (kind == K_HR) begin
            hr_end = cyc + HRC - 1;
            m_cnt = m_cnt + 8'd1;
        end
    endtask

    // Advance to the next falling edge and compare every output with the model
    task automatic tick();
        logic [6:0]  pm;
        logic [72:0] act;
        logic [72:0] expv;
        @(negedge sysClk);
        pm = 7'd0;
        for (int i = sched.size() - 1; i >= 0; i--) begin
            if (sched[i].at == cyc) begin
                apply(sched[i].kind, sched[i].f);
                pm[sched[i].kind] = 1'b1;
                sched.delete(i);
            end
        end
        expv = {m_i2c, m_comp, m_rgb, m_cam, m_ts, m_trig, m_ti,
                pm[K_CAP], pm[K_I2C], (cyc <= hr_end), pm[K_SEQ], pm[K_TO],
                pm[K_CK], pm[K_CMD], m_cnt};
        act  = {cam_i2c_byte, compression, RGB, cam_id, timestamp, trigger,
                trigger_index, cam_interface_output_valid, cam_i2c_output_valid,
                hard_reset, err_seq, err_timeout, err_cksum, err_cmd, good_frame_count};
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL cycle_outputs cyc=%0d got=%h expected=%h", cyc, act, expv);
        end
        if (hard_reset) hr_seen++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic put(input int num, input logic [7:0] val);
        tick();
        #1;
        spi_input_valid = 1'b1;
        spi_byte_num    = 4'(num);
        spi_byte        = val;
        last_c          = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            #1;
            spi_input_valid = 1'b0;
        end
    endtask

    task automatic put_bad(input int num, input logic [7:0] val);
        put(num, val);
        sched.push_back('{last_c + 1, K_SEQ, 72'h0});
    endtask

    task automatic send_frame(input logic [71:0] f);
        for (int i = 0; i < 9; i++) put(i, byte_of(f, i));
        sched.push_back('{last_c + 2, judge(f), f});
    endtask

    // Assert reset between clock edges, then release it a few cycles later
    task automatic reset_now();
        #2;
        sysRst_n = 1'b0;
        spi_input_valid = 1'b0;
        model_clear();
        repeat (3) tick();
        #1;
        sysRst_n = 1'b1;
    endtask

    logic [71:0] f;

    initial begin
        model_clear();
        repeat (3) tick();
        #1;
        sysRst_n = 1'b1;
        chk("reset_count", 32'(good_frame_count), 32'h0);

        // capture frame with literal bytes
        send_frame({8'h16, 8'h01, 8'h02, 8'h01, 8'h3D, 8'h2C, 8'h1B, 8'h0A, 8'h14});
        idle(3);
        chk("t1_timestamp", 32'(timestamp), 32'h0A1B2C3D);
        chk("t1_cam_id", 32'(cam_id), 32'h1);
        chk("t1_compression", 32'(compression), 32'h1);
        chk("t1_rgb", 32'(RGB), 32'h0);
        chk("t1_trigger", 32'(trigger), 32'h1);
        chk("t1_trigger_index", 32'(trigger_index), 32'h0102);
        chk("t1_count", 32'(good_frame_count), 32'h1);
        chk("t1_d2_timestamp", d2_ts, 32'h0A1B2C3D);

        // i2c frame
        send_frame({8'h1A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40});
        idle(3);
        chk("t2_i2c_byte", 32'(cam_i2c_byte), 32'h5A);
        chk("t2_cam_id", 32'(cam_id), 32'h0);
        chk("t2_timestamp_held", 32'(timestamp), 32'h0A1B2C3D);
        chk("t2_count", 32'(good_frame_count), 32'h2);

        // bad checksum: rejected here, accepted by the checksum-disabled instance
        send_frame({8'h17, 8'h01, 8'h02, 8'h01, 8'h3D, 8'h2C, 8'h1B, 8'h0A, 8'h14});
        idle(3);
        chk("t3_count", 32'(good_frame_count), 32'h2);
        chk("t3_d2_count", 32'(d2_cnt), 32'h3);

        // camera 3 out of range for NUM_CAMS=2, in range for NUM_CAMS=4
        send_frame(mk(8'h30, 32'h12345678, 16'hBEEF, 8'h00));
        idle(3);
        chk("t5_cam3_count", 32'(good_frame_count), 32'h2);
        chk("t5_d2_cam_id", 32'(d2_cam), 32'h3);
        chk("t5_d2_count", 32'(d2_cnt), 32'h4);

        // out-of-order index in RECV, and a non-zero index while IDLE
        f = mk(8'h04, 32'hCAFEF00D, 16'h0033, 8'h01);
        for (int i = 0; i < 3; i++) put(i, byte_of(f, i));
        put_bad(5, 8'hA5);
        idle(2);
        put_bad(3, 8'h11);
        idle(2);

        // byte 0 mid-frame restarts without error
        for (int i = 0; i < 4; i++) put(i, byte_of(f, i));
        send_frame(f);
        idle(3);
        chk("t4_restart_count", 32'(good_frame_count), 32'h3);

        // inter-byte timeout, then a normal frame
        for (int i = 0; i < 4; i++) put(i, byte_of(f, i));
        sched.push_back('{last_c + 1 + TOUT, K_TO, 72'h0});
        idle(TOUT + 3);
        send_frame(mk(8'h46, 32'h0, 16'h0, 8'hC3));
        idle(3);
        chk("t4_after_timeout_count", 32'(good_frame_count), 32'h4);
        chk("t4_after_timeout_i2c", 32'(cam_i2c_byte), 32'hC3);

        // hard reset pulse width and reserved opcode
        hr_seen = 0;
        send_frame(mk(8'hB0, 32'h0, 16'h0, 8'h00));
        idle(10);
        chk("t5_hard_reset_width", 32'(hr_seen), 32'd4);
        chk("t5_hr_count", 32'(good_frame_count), 32'h5);
        send_frame(mk(8'hC0, 32'h0, 16'h0, 8'h00));
        idle(3);
        chk("t5_op11_count", 32'(good_frame_count), 32'h5);

        // out-of-order byte during the check cycle; frame still completes
        send_frame(mk(8'h1E, 32'h00ABCDEF, 16'h7777, 8'h00));
        put_bad(3, 8'hEE);
        idle(3);
        chk("t6_check_cycle_ts", 32'(timestamp), 32'h00ABCDEF);

        // back-to-back frames, next byte 0 on the check cycle, counter wraps
        reset_now();
        for (int k = 0; k < 255; k++) begin
            send_frame(mk({1'b0, k[0], 1'b0, k[1], k[3:2], k[4], 1'b0},
                          32'(k) * 32'h01010101 + 32'd5, 16'(k * 3), 8'(k)));
        end
        idle(3);
        chk("t6_count_255", 32'(good_frame_count), 32'hFF);
        send_frame(mk(8'h00, 32'h1, 16'h1, 8'h00));
        idle(3);
        chk("t6_count_wrap", 32'(good_frame_count), 32'h0);

        // reset during byte 4 discards the partial frame
        f = mk(8'h14, 32'h0A1B2C3D, 16'h0102, 8'h01);
        for (int i = 0; i < 5; i++) put(i, byte_of(f, i));
        reset_now();
        idle(12);
        chk("t6_rst_timestamp", 32'(timestamp), 32'h0);
        chk("t6_rst_count", 32'(good_frame_count), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_frame_decoder.md
Name: spi_cmd_frame_decoder

Overview:
Parametrised successor to the main control block. It assembles fixed 9-byte command frames from the SPI byte interface and validates sequence, XOR checksum and field ranges. It decodes each frame into one of three outputs: a camera capture command, a camera I2C byte, or a hard-reset request. It sits between the SPI slave and the camera interface / camera I2C blocks, and adds inter-byte timeout, error strobes and a good-frame counter.

Parameters:
NUM_CAMS, 2, number of cameras addressable (1..4); a cam_id >= NUM_CAMS is rejected.
TS_WIDTH, 28, timestamp output width (1..32); low TS_WIDTH bits of the 32-bit frame field.
TIMEOUT_CYCLES, 1000, max sysClk cycles between bytes in a frame before abort (>=2).
CHECKSUM_EN, 1, 1 = byte 8 must equal XOR of bytes 0..7; 0 = byte 8 ignored.
HARD_RST_CYCLES, 4, width in cycles of the hard_reset pulse (>=1).

Ports:
sysClk  in  1  system clock, all logic on posedge
sysRst_n  in  1  asynchronous active-low reset
spi_byte  in  8  received SPI byte
spi_input_valid  in  1  1-cycle strobe: spi_byte/spi_byte_num valid
spi_byte_num  in  4  index of byte within frame (0..8)
cam_i2c_byte  out  8  I2C byte for camera
compression  out  2  compression mode
RGB  out  1  colour mode
cam_id  out  2  target camera
timestamp  out  TS_WIDTH  capture timestamp
trigger  out  1  trigger flag
trigger_index  out  16  trigger index
cam_interface_output_valid  out  1  1-cycle pulse, capture fields updated
cam_i2c_output_valid  out  1  1-cycle pulse, cam_i2c_byte/cam_id updated
hard_reset  out  1  HARD_RST_CYCLES-wide pulse
err_seq  out  1  1-cycle pulse, out-of-order byte
err_timeout  out  1  1-cycle pulse, inter-byte timeout
err_cksum  out  1  1-cycle pulse, checksum mismatch
err_cmd  out  1  1-cycle pulse, reserved opcode or cam_id out of range
good_frame_count  out  8  count of accepted frames, wraps 255->0

Behaviour:
- Reset (sysRst_n=0, async): all outputs 0, state IDLE, byte counter 0, timeout counter 0, frame buffer 0.
- Frame layout, big-endian:
  - byte0 header: [7:6] opcode (00 capture, 01 i2c, 10 hard reset, 11 reserved), [5:4] cam_id, [3:2] compression, [1] RGB, [0] ignored.
  - bytes1-4: timestamp[31:0].
  - bytes5-6: trigger_index.
  - byte7: bit0 = trigger (capture) or full byte = cam_i2c_byte (i2c).
  - byte8: checksum.
- States IDLE, RECV, CHECK. A byte is accepted only on a spi_input_valid cycle.
- IDLE: byte_num==0 -> store byte0, expected=1, go to RECV. Any other byte_num -> err_seq, stay in IDLE.
- RECV:
  - byte_num==expected -> store, expected+1; after byte 8 go to CHECK.
  - byte_num==0 -> restart frame with this byte, no error.
  - Other index -> err_seq, go to IDLE.
  - Timeout counter clears on every accepted byte. Reaching TIMEOUT_CYCLES with no valid -> err_timeout, go to IDLE.
- CHECK (exactly 1 cycle). Priority: checksum (if CHECKSUM_EN), then opcode 11 / cam_id>=NUM_CAMS. First failure pulses its err_* and no fields change.
- On success, the field registers and the matching valid pulse update on the same edge that leaves CHECK. Latency: last byte strobe at edge N -> valid high during cycle N+1..N+2, i.e. the valid is high exactly 1 cycle, starting 2 edges after the byte-8 edge.
  - capture updates cam_id, compression, RGB, timestamp, trigger, trigger_index.
  - i2c updates cam_id and cam_i2c_byte only.
  - hard reset raises hard_reset for HARD_RST_CYCLES cycles and changes no fields. A new hard-reset command during the pulse restarts the width count.
  - good_frame_count increments on every successful frame.
- Decoded fields hold their values between frames.
- A valid with byte_num==0 during CHECK is accepted as byte0 of the next frame (go to RECV after the check completes). Any other valid during CHECK -> err_seq, byte dropped.
- Error strobes never coincide with a valid pulse for the same frame.
- Reset asserted mid-frame discards the partial frame; no pulse is emitted.

Test Plan:
1. Capture frame 14 0A 1B 2C 3D 01 02 01 16, TS_WIDTH=28 -> cam_interface_output_valid 1 cycle; cam_id=1, compression=1, RGB=0, timestamp=0xA1B2C3D, trigger=1, trigger_index=0x0102, good_frame_count=1.
2. I2C frame 40 00 00 00 00 00 00 5A 1A -> cam_i2c_output_valid 1 cycle; cam_i2c_byte=0x5A, cam_id=0; capture fields unchanged.
3. Same as 1 with byte8=0x17 -> err_cksum pulse, no valid, fields unchanged. With CHECKSUM_EN=0 -> accepted.
4. Bytes 0,1,2 then byte_num=5 -> err_seq, IDLE. Bytes 0..3 then idle for TIMEOUT_CYCLES -> err_timeout. Next valid frame is accepted normally.
5. Header 0xB0 (opcode 10) with correct checksum -> hard_reset high exactly 4 cycles. Header 0x30 with NUM_CAMS=2 (cam 3) -> err_cmd. Opcode 11 -> err_cmd.
6. 256 back-to-back good frames, byte0 of next frame on the CHECK cycle -> none lost, count wraps to 0. sysRst_n low during byte 4 -> all outputs 0, no pulse.
